// File: rtl/mem_access_unit.sv
// Word-wide memory initiator for RV32I loads/stores; sub-word stores via read-modify-write.
// Accept->rsp_valid: error 1, load/SW 2, SB/SH 3 cycles; req_ready only in IDLE, response held until rsp_ready.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_wdata;

  logic        w_illegal;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_illegal  = req_we ? (req_funct3 > 3'd2)
                             : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_misalign = CHECK_ALIGN &&
                      (((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)));

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'h0, w_byte};
      3'd5:    w_load = {16'h0, w_half};
      default: w_load = mem_rdata;
    endcase

    // Only SB/SH reach the merge; with alignment checks off the half lane ignores addr[0].
    w_merged = mem_rdata;
    if (r_funct3[1:0] == 2'd0)
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_lane        <= 2'd0;
      r_wdata       <= 16'h0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'h0;
      r_rsp_err     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            if (w_illegal || w_misalign) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_state     <= S_RESP;
            end else begin
              r_mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_we && (req_funct3 == 3'd2)) begin
                r_mem_wdata <= req_wdata;
                r_mem_we    <= 1'b1;
                r_state     <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (r_we) begin
            r_mem_wdata <= w_merged;
            r_mem_we    <= 1'b1;
            r_state     <= S_WRITE;
          end else begin
            r_rsp_rdata <= w_load;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_we    <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign mem_we      = r_mem_we;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes model expectations, monitor pops on response handshake.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  // Memory: combinational read, write on posedge, decodes address bits [7:2] only.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        tb_load = 1'b0;

  assign mem_rdata = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_address[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          we_base;
    int          pulses;
    logic [31:0] maddr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   we_total = 0;
  int   stall    = 0;
  bit   seen     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_we) begin
        we_total++;
        if (q.size() > 0) chk("mem_address", mem_address, q[0].maddr);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          timeout("unexpected_rsp");
        end else begin
          chk("rsp_rdata", rsp_rdata, q[0].rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, q[0].err});
          chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - q[0].acc, q[0].lat);
          end
          if (rsp_ready) begin
            chk("we_pulses", we_total - q[0].we_base, q[0].pulses);
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Response acceptor: random readiness, with an optional forced stall once valid.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid && stall > 0) begin
        rsp_ready = 1'b0;
        stall--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    exp_t        e;
    int          n;
    int          idx;
    int          sh;
    int          hsh;
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] mask;
    logic        illegal;
    logic        mis;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      timeout("req_ready_wait");
      return;
    end
    idx  = int'(addr[7:2]);
    sh   = 8 * int'(addr[1:0]);
    hsh  = 16 * int'(addr[1]);
    word = ref_mem[idx];
    b    = (word >> sh) & 32'hFF;
    h    = (word >> hsh) & 32'hFFFF;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis     = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
    e.err    = illegal || mis;
    e.rdata  = 32'h0;
    e.pulses = 0;
    e.maddr  = addr & ~32'h3;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      case (f3)
        3'd0:    e.rdata = b[7]  ? (b | 32'hFFFFFF00) : b;
        3'd1:    e.rdata = h[15] ? (h | 32'hFFFF0000) : h;
        3'd4:    e.rdata = b;
        3'd5:    e.rdata = h;
        default: e.rdata = word;
      endcase
    end else begin
      e.pulses = 1;
      if (f3 == 3'd2) begin
        e.lat = 2;
        word  = wd;
      end else begin
        e.lat = 3;
        mask  = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << hsh);
        word  = (word & ~mask) | ((wd << ((f3 == 3'd0) ? sh : hsh)) & mask);
      end
      if (track) ref_mem[idx] = word;
    end
    e.acc     = cyc;
    e.we_base = we_total;
    if (track) q.push_back(e);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !req_ready) timeout("drain");
  endtask

  task automatic load_mem();
    @(negedge clk);
    tb_load = 1'b1;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom();
    ref_mem[4] = 32'h8070_60F0;
    ref_mem[8] = 32'h1122_3344;
    tb_load = 1'b1;
    #22;
    tb_load = 1'b0;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1);
    issue(1'b1, 3'd0, 32'h21, 32'hAB, 1'b1);
    drain();
    chk("sb_merge_mem", mem[8], 32'h1122_AB44);
    ref_mem[8] = 32'h1122_3344;
    load_mem();
    issue(1'b1, 3'd1, 32'h22, 32'hBEEF, 1'b1);
    issue(1'b1, 3'd2, 32'h24, 32'hCAFE_F00D, 1'b1);
    drain();
    chk("sh_merge_mem", mem[8], 32'hBEEF_3344);
    chk("sw_mem", mem[9], 32'hCAFE_F00D);

    issue(1'b0, 3'd2, 32'h11, 32'h0, 1'b1);
    issue(1'b1, 3'd1, 32'h23, 32'h1234, 1'b1);
    issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
    drain();

    stall = 5;
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    drain();

    // Reset in the WRITE cycle of a byte store: nothing may be committed.
    issue(1'b1, 3'd0, 32'h31, 32'h5A, 1'b0);
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!mem_we) timeout("mem_we_wait");
    resetn = 1'b0;
    #1;
    chk("rst_mid_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_kept", mem[12], ref_mem[12]);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), 1'b1);
    end
    drain();
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
